pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32IM pipeline. Per cycle, it merges four hazard sources into one consistent set of register enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB:
- load-use bubble request from the hazard unit
- multi-cycle MUL/DIV occupancy in EX
- branch redirect from EX
- data-memory wait

It owns the MUL/DIV start/done handshake, a watchdog, and a stall-cycle counter.

---
 rtl/pipeline_stall_controller_pkg.sv | 21 ++
 rtl/pipeline_stall_controller_sat_counter.sv | 27 ++
 rtl/pipeline_stall_controller.sv | 193 +++++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline-control definitions: FSM state encodings and stage indices
// used by the stall controller and the hazard/forwarding units.
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_LOAD_STALL  = 2'd1,
        ST_MULDIV_WAIT = 2'd2,
        ST_MEM_WAIT    = 2'd3
    } state_e;

    // Stage indices; the enable vector bit for a stage register is the index
    // of the stage it feeds (PC feeds IF, IF/ID feeds ID, ...).
    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;
    localparam int unsigned NUM_STG = 5;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment)
// and asynchronous active-low reset.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         INC,
    input  logic         CLR,
    output logic [W-1:0] COUNT
);

    logic [W-1:0] r_count;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_count <= '0;
        end else if (CLR) begin
            r_count <= '0;
        end else if (INC && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign COUNT = r_count;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges load-use,
// MUL/DIV occupancy, branch redirect and data-memory wait into stage controls.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned MULDIV_TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD_USE_BUBBLE,
    input  logic             EX_MULDIV,
    input  logic             MULDIV_DONE,
    input  logic             BRANCH_TAKEN,
    input  logic             MEM_ACCESS,
    input  logic             DMEM_READY,
    output logic             PC_EN,
    output logic             IFID_EN,
    output logic             IDEX_EN,
    output logic             EXMEM_EN,
    output logic             MEMWB_EN,
    output logic             IFID_FLUSH,
    output logic             IDEX_FLUSH,
    output logic             EXMEM_FLUSH,
    output logic             MULDIV_GO,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] STALL_CYCLES,
    output logic             TIMEOUT_ERR
);

    localparam int unsigned WD_W = $clog2(MULDIV_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MULDIV_TIMEOUT - 1);

    state_e               r_state;
    state_e               r_resume;
    logic                 r_done_pending;
    logic                 r_timeout_err;
    state_e               w_next;
    state_e               w_resume_next;
    logic                 w_pend_next;
    logic                 w_timeout;
    logic                 w_mem_stall;
    logic                 w_muldiv_open;
    logic [NUM_STG-1:0]   w_en;
    logic                 w_ifid_fl;
    logic                 w_idex_fl;
    logic                 w_exmem_fl;
    logic                 w_go;
    logic [WD_W-1:0]      w_wd_count;

    assign w_mem_stall   = MEM_ACCESS && !DMEM_READY;
    // A MUL/DIV is outstanding either in MULDIV_WAIT or while parked in MEM_WAIT
    // with MULDIV_WAIT as the resume target; only then is a DONE worth keeping.
    assign w_muldiv_open = (r_state == ST_MULDIV_WAIT) ||
                           ((r_state == ST_MEM_WAIT) && (r_resume == ST_MULDIV_WAIT));

    always_comb begin
        w_en          = '1;
        w_ifid_fl     = 1'b0;
        w_idex_fl     = 1'b0;
        w_exmem_fl    = 1'b0;
        w_go          = 1'b0;
        w_next        = r_state;
        w_resume_next = r_resume;
        w_pend_next   = r_done_pending;
        w_timeout     = 1'b0;

        if (w_mem_stall) begin
            w_en   = '0;
            w_next = ST_MEM_WAIT;
            if (r_state != ST_MEM_WAIT) begin
                w_resume_next = r_state;
            end
            if (MULDIV_DONE && w_muldiv_open) begin
                w_pend_next = 1'b1;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (EX_MULDIV) begin
                        w_go           = 1'b1;
                        w_en[STG_IF]   = 1'b0;
                        w_en[STG_ID]   = 1'b0;
                        w_en[STG_EX]   = 1'b0;
                        w_exmem_fl     = 1'b1;
                        w_pend_next    = 1'b0;
                        w_next         = ST_MULDIV_WAIT;
                    end else if (BRANCH_TAKEN) begin
                        w_ifid_fl = 1'b1;
                        w_idex_fl = 1'b1;
                    end else if (LOAD_USE_BUBBLE) begin
                        w_en[STG_IF] = 1'b0;
                        w_en[STG_ID] = 1'b0;
                        w_idex_fl    = 1'b1;
                        w_next       = ST_LOAD_STALL;
                    end
                end
                ST_LOAD_STALL: begin
                    w_next = ST_RUN;
                end
                ST_MULDIV_WAIT: begin
                    if (MULDIV_DONE || r_done_pending) begin
                        w_pend_next = 1'b0;
                        w_next      = ST_RUN;
                    end else begin
                        w_en[STG_IF] = 1'b0;
                        w_en[STG_ID] = 1'b0;
                        w_en[STG_EX] = 1'b0;
                        w_exmem_fl   = 1'b1;
                        if (w_wd_count >= WD_LIMIT) begin
                            w_timeout = 1'b1;
                            w_next    = ST_RUN;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    // Exit cycle: the front end stays held if a MUL/DIV is still
                    // in EX; a DONE here is banked so it completes back in MULDIV_WAIT.
                    w_next = r_resume;
                    if (r_resume == ST_MULDIV_WAIT) begin
                        w_en[STG_IF] = 1'b0;
                        w_en[STG_ID] = 1'b0;
                        w_en[STG_EX] = 1'b0;
                        w_exmem_fl   = 1'b1;
                        if (MULDIV_DONE) begin
                            w_pend_next = 1'b1;
                        end
                    end
                end
                default: begin
                    w_next = ST_RUN;
                end
            endcase
        end

        if (!RESET) begin
            w_en       = '0;
            w_ifid_fl  = 1'b0;
            w_idex_fl  = 1'b0;
            w_exmem_fl = 1'b0;
            w_go       = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state        <= ST_RUN;
            r_resume       <= ST_RUN;
            r_done_pending <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_resume       <= w_resume_next;
            r_done_pending <= w_pend_next;
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (!w_en[STG_IF]),
        .CLR   (1'b0),
        .COUNT (STALL_CYCLES)
    );

    sat_counter #(
        .W (WD_W)
    ) u_watchdog (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (r_state == ST_MULDIV_WAIT),
        .CLR   (w_go),
        .COUNT (w_wd_count)
    );

    assign PC_EN       = w_en[STG_IF];
    assign IFID_EN     = w_en[STG_ID];
    assign IDEX_EN     = w_en[STG_EX];
    assign EXMEM_EN    = w_en[STG_MEM];
    assign MEMWB_EN    = w_en[STG_WB];
    assign IFID_FLUSH  = w_ifid_fl;
    assign IDEX_FLUSH  = w_idex_fl;
    assign EXMEM_FLUSH = w_exmem_fl;
    assign MULDIV_GO   = w_go;
    assign STATE       = r_state;
    assign TIMEOUT_ERR = r_timeout_err;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed scenarios plus
// randomized traffic compared each cycle against a behavioural model.
module tb_pipeline_stall_controller;

    localparam int unsigned CW        = 6;
    localparam int unsigned TMO       = 8;
    localparam int unsigned STALL_MAX = (1 << CW) - 1;
    localparam int unsigned WD_MAX    = 15;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          LOAD_USE_BUBBLE = 1'b0;
    logic          EX_MULDIV = 1'b0;
    logic          MULDIV_DONE = 1'b0;
    logic          BRANCH_TAKEN = 1'b0;
    logic          MEM_ACCESS = 1'b0;
    logic          DMEM_READY = 1'b1;
    logic          PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN;
    logic          IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH, MULDIV_GO;
    logic [1:0]    STATE;
    logic [CW-1:0] STALL_CYCLES;
    logic          TIMEOUT_ERR;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: mode numbers follow the documented state values
    // (0 run, 1 load bubble, 2 waiting on MUL/DIV, 3 waiting on memory).
    int unsigned m_state  = 0;
    int unsigned m_resume = 0;
    int unsigned m_wd     = 0;
    int unsigned m_stalls = 0;
    bit          m_pend   = 0;
    bit          m_err    = 0;

    pipeline_stall_controller #(
        .CNT_W          (CW),
        .MULDIV_TIMEOUT (TMO)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .LOAD_USE_BUBBLE (LOAD_USE_BUBBLE),
        .EX_MULDIV       (EX_MULDIV),
        .MULDIV_DONE     (MULDIV_DONE),
        .BRANCH_TAKEN    (BRANCH_TAKEN),
        .MEM_ACCESS      (MEM_ACCESS),
        .DMEM_READY      (DMEM_READY),
        .PC_EN           (PC_EN),
        .IFID_EN         (IFID_EN),
        .IDEX_EN         (IDEX_EN),
        .EXMEM_EN        (EXMEM_EN),
        .MEMWB_EN        (MEMWB_EN),
        .IFID_FLUSH      (IFID_FLUSH),
        .IDEX_FLUSH      (IDEX_FLUSH),
        .EXMEM_FLUSH     (EXMEM_FLUSH),
        .MULDIV_GO       (MULDIV_GO),
        .STATE           (STATE),
        .STALL_CYCLES    (STALL_CYCLES),
        .TIMEOUT_ERR     (TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] ctl_obs();
        return {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN,
                IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH, MULDIV_GO};
    endfunction

    // One clock: drive inputs, compare at the falling edge, advance the model.
    task automatic step(input bit lu, input bit mul, input bit done,
                        input bit br, input bit mem, input bit rdy);
        bit [4:0]    en;
        bit [2:0]    fl;
        bit          go;
        int unsigned nst, nres;
        bit          npend, nerr;
        @(posedge CLK);
        #1;
        LOAD_USE_BUBBLE = lu;
        EX_MULDIV       = mul;
        MULDIV_DONE     = done;
        BRANCH_TAKEN    = br;
        MEM_ACCESS      = mem;
        DMEM_READY      = rdy;
        @(negedge CLK);
        en = 5'b11111; fl = 3'b000; go = 1'b0;
        nst = m_state; nres = m_resume; npend = m_pend; nerr = m_err;
        if (mem && !rdy) begin
            en  = 5'b00000;
            nst = 3;
            if (m_state != 3) nres = m_state;
            if (done && (m_state == 2 || (m_state == 3 && m_resume == 2))) npend = 1;
        end else if (m_state == 0) begin
            if (mul) begin
                go = 1; en = 5'b00011; fl = 3'b001; nst = 2; npend = 0;
            end else if (br) begin
                fl = 3'b110;
            end else if (lu) begin
                en = 5'b00111; fl = 3'b010; nst = 1;
            end
        end else if (m_state == 1) begin
            nst = 0;
        end else if (m_state == 2) begin
            if (done || m_pend) begin
                nst = 0; npend = 0;
            end else begin
                en = 5'b00011; fl = 3'b001;
                if (m_wd + 1 >= TMO) begin
                    nerr = 1; nst = 0;
                end
            end
        end else begin
            nst = m_resume;
            if (m_resume == 2) begin
                en = 5'b00011; fl = 3'b001;
                if (done) npend = 1;
            end
        end
        check_val("ctl", ctl_obs(), {en, fl, go});
        check_val("state", STATE, m_state);
        check_val("stall_cycles", STALL_CYCLES, m_stalls);
        check_val("timeout_err", TIMEOUT_ERR, m_err);
        if (!en[4] && m_stalls < STALL_MAX) m_stalls++;
        if (go) m_wd = 0;
        else if (m_state == 2 && m_wd < WD_MAX) m_wd++;
        m_state = nst; m_resume = nres; m_pend = npend; m_err = nerr;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
    endtask

    // Hold reset low for n cycles with random input noise; everything must read zero.
    task automatic reset_phase(input int unsigned n);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            LOAD_USE_BUBBLE = 1'($urandom);
            EX_MULDIV       = 1'($urandom);
            MULDIV_DONE     = 1'($urandom);
            BRANCH_TAKEN    = 1'($urandom);
            MEM_ACCESS      = 1'($urandom);
            DMEM_READY      = 1'($urandom);
            @(negedge CLK);
            check_val("rst_ctl", ctl_obs(), 9'd0);
            check_val("rst_state", STATE, 0);
            check_val("rst_stall", STALL_CYCLES, 0);
            check_val("rst_terr", TIMEOUT_ERR, 0);
            @(posedge CLK);
            #1;
        end
        LOAD_USE_BUBBLE = 0; EX_MULDIV = 0; MULDIV_DONE = 0;
        BRANCH_TAKEN = 0; MEM_ACCESS = 0; DMEM_READY = 1;
        RESET = 1'b1;
        m_state = 0; m_resume = 0; m_wd = 0; m_stalls = 0; m_pend = 0; m_err = 0;
    endtask

    initial begin
        reset_phase(3);

        // Load-use held two cycles: exactly one bubble.
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        idle(2);

        // Branch together with load-use: branch wins.
        step(1, 0, 0, 1, 0, 1);
        idle(1);

        // DIV with DONE five cycles after GO.
        step(0, 1, 0, 0, 0, 1);
        for (int unsigned i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        idle(2);

        // Memory wait spanning DONE during a MUL/DIV.
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 1, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 1);
        step(0, 1, 0, 0, 0, 1);
        idle(2);

        // Watchdog timeout, sticky until reset.
        step(0, 1, 0, 0, 0, 1);
        for (int unsigned i = 0; i < TMO; i++) step(0, 1, 0, 0, 0, 1);
        idle(4);
        step(0, 0, 1, 0, 0, 1);
        reset_phase(2);
        idle(1);

        // Reset in the middle of a MUL/DIV, then a stray DONE.
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        reset_phase(2);
        step(0, 0, 1, 0, 0, 1);
        idle(2);

        // Long memory stall drives the stall counter into saturation.
        for (int unsigned i = 0; i < STALL_MAX + 8; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        idle(2);
        step(1, 0, 0, 0, 0, 1);
        idle(1);

        // Randomized traffic with periodic resets.
        for (int unsigned blk = 0; blk < 12; blk++) begin
            reset_phase(1 + $urandom_range(0, 2));
            for (int unsigned i = 0; i < 200; i++) begin
                step($urandom_range(0, 99) < 20,
                     $urandom_range(0, 99) < 15,
                     $urandom_range(0, 99) < 12,
                     $urandom_range(0, 99) < 15,
                     $urandom_range(0, 99) < 40,
                     $urandom_range(0, 99) < 70);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
